// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router packet definitions: FSM states, header layout, limits
package router_pkg;

  localparam int ADDR_W   = 2;
  localparam int LEN_W    = 6;
  localparam int ADDR_LSB = 0;
  localparam int LEN_LSB  = ADDR_W;
  localparam int BYTE_W   = 8;
  localparam int MAX_LEN  = 63;

  localparam logic [ADDR_W-1:0] BAD_ADDR = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY
  } tx_state_t;

  function automatic logic [BYTE_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    logic [BYTE_W-1:0] hdr;
    hdr = '0;
    hdr[LEN_LSB +: LEN_W]   = len;
    hdr[ADDR_LSB +: ADDR_W] = addr;
    return hdr;
  endfunction

  function automatic logic header_ok(input logic [ADDR_W-1:0] addr,
                                     input logic [LEN_W-1:0]  len);
    return (addr != BAD_ADDR) && (len != '0);
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - host payload and router byte-stream signals of the packet transmitter
interface router_pkt_tx_if;
  import router_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] dest_addr;
  logic [LEN_W-1:0]  payload_len;
  logic [BYTE_W-1:0] pl_data;
  logic              pl_valid;
  logic              pl_ready;
  logic              busy;
  logic [BYTE_W-1:0] data_in;
  logic              pkt_valid;
  logic              tx_active;
  logic              tx_done;
  logic              err;

  modport master (
    input  start, dest_addr, payload_len, pl_data, pl_valid, busy,
    output pl_ready, data_in, pkt_valid, tx_active, tx_done, err
  );

  modport slave (
    output start, dest_addr, payload_len, pl_data, pl_valid, busy,
    input  pl_ready, data_in, pkt_valid, tx_active, tx_done, err
  );

endinterface

// File: rtl/router_pkt_tx_buf.sv
// rtl/router_pkt_tx_buf.sv - payload store, one write port and one read port with registered read address
module router_pkt_tx_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_addr_q;

  // Contents are never reset; a packet only reads bytes it has written.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= rd_addr;
    end
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - packet transmitter: buffers a payload from the host, then sends
// header, payload and XOR parity to the router under busy back-pressure.
module router_pkt_tx
  import router_pkg::*;
(
  input  logic            clock,
  input  logic            resetn,
  router_pkt_tx_if.master bus
);

  tx_state_t         state, state_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic [BYTE_W-1:0] parity, parity_n;
  logic [BYTE_W-1:0] data_q, data_n;
  logic              pkt_valid_q, pkt_valid_n;
  logic              pl_ready_q, pl_ready_n;
  logic              tx_active_q;
  logic              tx_done_q, tx_done_n;
  logic              err_q, err_n;

  logic              wr_en;
  logic [LEN_W-1:0]  rd_addr;
  logic [BYTE_W-1:0] rd_data;
  logic              accept;
  logic              take;

  assign accept = pl_ready_q && bus.pl_valid;
  assign take   = !bus.busy;

  always_comb begin
    state_n     = state;
    len_n       = len_q;
    addr_n      = addr_q;
    cnt_n       = cnt;
    parity_n    = parity;
    data_n      = data_q;
    pkt_valid_n = pkt_valid_q;
    pl_ready_n  = 1'b0;
    tx_done_n   = 1'b0;
    err_n       = 1'b0;
    wr_en       = 1'b0;

    case (state)
      IDLE: begin
        data_n      = '0;
        pkt_valid_n = 1'b0;
        // The tx_done cycle is a guard cycle: start is not sampled then.
        if (bus.start && !tx_done_q) begin
          if (header_ok(bus.dest_addr, bus.payload_len)) begin
            state_n    = LOAD;
            len_n      = bus.payload_len;
            addr_n     = bus.dest_addr;
            cnt_n      = '0;
            parity_n   = make_header(bus.payload_len, bus.dest_addr);
            pl_ready_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      LOAD: begin
        pl_ready_n = 1'b1;
        if (accept) begin
          wr_en    = 1'b1;
          parity_n = parity ^ bus.pl_data;
          cnt_n    = cnt + LEN_W'(1);
          if (cnt == len_q - LEN_W'(1)) begin
            state_n     = HEADER;
            cnt_n       = '0;
            pl_ready_n  = 1'b0;
            data_n      = make_header(len_q, addr_q);
            pkt_valid_n = 1'b1;
          end
        end
      end

      HEADER: begin
        if (take) begin
          state_n = PAYLOAD;
          data_n  = rd_data;
        end
      end

      PAYLOAD: begin
        if (take) begin
          if (cnt == len_q - LEN_W'(1)) begin
            state_n     = PARITY;
            cnt_n       = '0;
            data_n      = parity;
            pkt_valid_n = 1'b0;
          end else begin
            cnt_n  = cnt + LEN_W'(1);
            data_n = rd_data;
          end
        end
      end

      PARITY: begin
        if (take) begin
          state_n   = IDLE;
          data_n    = '0;
          tx_done_n = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Read one byte ahead so the next payload byte is ready at the edge that takes the current one.
  assign rd_addr = (state_n == PAYLOAD) ? cnt_n + LEN_W'(1) : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      cnt         <= '0;
      parity      <= '0;
      data_q      <= '0;
      pkt_valid_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      len_q       <= len_n;
      addr_q      <= addr_n;
      cnt         <= cnt_n;
      parity      <= parity_n;
      data_q      <= data_n;
      pkt_valid_q <= pkt_valid_n;
      pl_ready_q  <= pl_ready_n;
      tx_active_q <= (state_n != IDLE);
      tx_done_q   <= tx_done_n;
      err_q       <= err_n;
    end
  end

  router_pkt_tx_buf #(
    .DEPTH (MAX_LEN + 1),
    .AW    (LEN_W),
    .DW    (BYTE_W)
  ) u_buf (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_addr (cnt),
    .wr_data (bus.pl_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign bus.data_in   = data_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pl_ready  = pl_ready_q;
  assign bus.tx_active = tx_active_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - directed and randomized bench for router_pkt_tx against a byte-list model
module tb_router_pkt_tx;
  import router_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  router_pkt_tx_if bus ();

  router_pkt_tx dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Model: a packet is a list of bytes (header, payload, parity) walked one byte per non-busy edge.
  int         m_phase = 0;  // 0 idle, 1 collecting payload, 2 sending
  int         m_want  = 0;
  int         m_pos   = 0;
  logic       m_done  = 1'b0;
  logic       m_err   = 1'b0;
  logic [7:0] m_pkt[$];

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_phase = 0;
      m_pos   = 0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_pkt.delete();
    end else begin : step
      logic       nd;
      logic       ne;
      logic [7:0] p;
      nd = 1'b0;
      ne = 1'b0;
      if (m_phase == 0) begin
        if (bus.start && !m_done) begin
          if (bus.dest_addr == 2'd3 || bus.payload_len == 6'd0) begin
            ne = 1'b1;
          end else begin
            m_phase = 1;
            m_want  = int'(bus.payload_len);
            m_pkt.delete();
            m_pkt.push_back({bus.payload_len, bus.dest_addr});
          end
        end
      end else if (m_phase == 1) begin
        if (bus.pl_valid) begin
          m_pkt.push_back(bus.pl_data);
          if (m_pkt.size() == m_want + 1) begin
            p = 8'h00;
            foreach (m_pkt[i]) p = p ^ m_pkt[i];
            m_pkt.push_back(p);
            m_phase = 2;
            m_pos   = 0;
          end
        end
      end else begin
        if (!bus.busy) begin
          m_pos = m_pos + 1;
          if (m_pos == m_pkt.size()) begin
            m_phase = 0;
            nd      = 1'b1;
          end
        end
      end
      m_done = nd;
      m_err  = ne;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin : compare
    logic [7:0] ed;
    logic       ev;
    ev = (m_phase == 2) && (m_pos < m_pkt.size() - 1);
    ed = (m_phase == 2) ? m_pkt[m_pos] : 8'h00;
    check("data_in",   bus.data_in,        ed);
    check("pkt_valid", 8'(bus.pkt_valid),  8'(ev));
    check("pl_ready",  8'(bus.pl_ready),   8'(m_phase == 1));
    check("tx_active", 8'(bus.tx_active),  8'(m_phase != 0));
    check("tx_done",   8'(bus.tx_done),    8'(m_done));
    check("err",       8'(bus.err),        8'(m_err));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},   bus.data_in,          8'h00);
    check({tag, "_pv"},     8'(bus.pkt_valid),    8'h00);
    check({tag, "_ready"},  8'(bus.pl_ready),     8'h00);
    check({tag, "_active"}, 8'(bus.tx_active),    8'h00);
    check({tag, "_done"},   8'(bus.tx_done),      8'h00);
    check({tag, "_err"},    8'(bus.err),          8'h00);
  endtask

  logic [7:0] pay33  [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       busy33 [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] data33 [11] = '{8'h12, 8'h12, 8'h12, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h56, 8'h00};

  initial begin
    bus.start       = 1'b0;
    bus.dest_addr   = '0;
    bus.payload_len = '0;
    bus.pl_data     = '0;
    bus.pl_valid    = 1'b0;
    bus.busy        = 1'b0;
    resetn          = 1'b0;
    tick();
    tick();
    check_zero("reset");
    resetn = 1'b1;
    tick();

    // addr 1, len 3, no back-pressure
    bus.start = 1'b1; bus.dest_addr = 2'd1; bus.payload_len = 6'd3;
    tick();
    bus.start = 1'b0; bus.pl_valid = 1'b1; bus.pl_data = 8'hA5;
    tick();
    bus.pl_data = 8'h3C;
    tick();
    bus.pl_data = 8'hFF;
    tick();
    bus.pl_valid = 1'b0;
    check("model_parity", m_pkt[4], 8'h6B);
    check("p1_hdr", bus.data_in, 8'h0D);
    check("p1_hdr_pv", 8'(bus.pkt_valid), 8'h01);
    tick(); check("p1_b0", bus.data_in, 8'hA5);
    tick(); check("p1_b1", bus.data_in, 8'h3C);
    tick(); check("p1_b2", bus.data_in, 8'hFF);
    tick(); check("p1_par", bus.data_in, 8'h6B);
    check("p1_par_pv", 8'(bus.pkt_valid), 8'h00);
    tick(); check("p1_done", 8'(bus.tx_done), 8'h01);
    check("p1_idle_data", bus.data_in, 8'h00);
    tick();
    tick();

    // addr 2, len 4, stalls on header and payload byte 1
    bus.start = 1'b1; bus.dest_addr = 2'd2; bus.payload_len = 6'd4;
    tick();
    bus.start = 1'b0; bus.pl_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.pl_data = pay33[i];
      tick();
    end
    bus.pl_valid = 1'b0;
    check("p2_hdr", bus.data_in, 8'h12);
    for (int i = 0; i < 11; i++) begin
      bus.busy = busy33[i];
      tick();
      check($sformatf("p2_edge%0d", i + 1), bus.data_in, data33[i]);
    end
    check("p2_done", 8'(bus.tx_done), 8'h01);
    bus.busy = 1'b0;
    tick();
    tick();

    // invalid starts
    bus.start = 1'b1; bus.dest_addr = 2'd3; bus.payload_len = 6'd5;
    tick();
    check("e1_err", 8'(bus.err), 8'h01);
    check("e1_ready", 8'(bus.pl_ready), 8'h00);
    check("e1_pv", 8'(bus.pkt_valid), 8'h00);
    bus.start = 1'b0;
    tick();
    check("e1_err_clr", 8'(bus.err), 8'h00);
    bus.start = 1'b1; bus.dest_addr = 2'd0; bus.payload_len = 6'd0;
    tick();
    check("e2_err", 8'(bus.err), 8'h01);
    check("e2_active", 8'(bus.tx_active), 8'h00);
    bus.start = 1'b0;
    tick();
    check("e2_err_clr", 8'(bus.err), 8'h00);
    check("e2_ready", 8'(bus.pl_ready), 8'h00);

    // len 2 with pl_valid 1,0,0,1
    bus.start = 1'b1; bus.dest_addr = 2'd0; bus.payload_len = 6'd2;
    tick();
    bus.start = 1'b0; bus.pl_valid = 1'b1; bus.pl_data = 8'h5A;
    tick();
    bus.pl_valid = 1'b0; bus.pl_data = 8'hEE;
    tick();
    tick();
    check("v_still_load", 8'(bus.pl_ready), 8'h01);
    check("v_no_hdr", 8'(bus.pkt_valid), 8'h00);
    bus.pl_valid = 1'b1; bus.pl_data = 8'hC3;
    tick();
    bus.pl_valid = 1'b0;
    check("v_ready_off", 8'(bus.pl_ready), 8'h00);
    check("v_hdr", bus.data_in, 8'h08);
    tick(); check("v_b0", bus.data_in, 8'h5A);
    tick(); check("v_b1", bus.data_in, 8'hC3);
    tick(); check("v_par", bus.data_in, 8'h91);
    tick(); check("v_done", 8'(bus.tx_done), 8'h01);
    tick();

    // reset during payload byte 2 of 10
    bus.start = 1'b1; bus.dest_addr = 2'd1; bus.payload_len = 6'd10;
    tick();
    bus.start = 1'b0; bus.pl_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.pl_data = 8'(i * 7 + 1);
      tick();
    end
    bus.pl_valid = 1'b0;
    tick();
    tick();
    tick();
    check("r_b2", bus.data_in, 8'd15);
    resetn = 1'b0;
    #1;
    check_zero("r_async");
    tick();
    resetn = 1'b1;
    tick();
    check_zero("r_after");
    bus.start = 1'b1; bus.dest_addr = 2'd2; bus.payload_len = 6'd1;
    tick();
    bus.start = 1'b0; bus.pl_valid = 1'b1; bus.pl_data = 8'h9C;
    tick();
    bus.pl_valid = 1'b0;
    check("r_hdr", bus.data_in, 8'h06);
    tick(); check("r_b0", bus.data_in, 8'h9C);
    tick(); check("r_par", bus.data_in, 8'h9A);
    tick(); check("r_done", 8'(bus.tx_done), 8'h01);
    tick();

    // two len-63 packets with start held high
    bus.start = 1'b1; bus.dest_addr = 2'd0; bus.payload_len = 6'd63; bus.pl_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      bus.pl_data = 8'($urandom);
      tick();
      if (bus.tx_done) break;
    end
    check("b2b_done1", 8'(bus.tx_done), 8'h01);
    tick();
    check("b2b_gap_ready", 8'(bus.pl_ready), 8'h00);
    check("b2b_gap_active", 8'(bus.tx_active), 8'h00);
    tick();
    check("b2b_restart", 8'(bus.pl_ready), 8'h01);
    bus.start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bus.pl_data = 8'($urandom);
      tick();
      if (bus.tx_done) break;
    end
    check("b2b_done2", 8'(bus.tx_done), 8'h01);
    bus.pl_valid = 1'b0;
    tick();
    tick();

    // randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.dest_addr = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin
        bus.payload_len = 6'($urandom_range(0, 63));
      end else begin
        bus.payload_len = 6'($urandom_range(1, 6));
      end
      bus.pl_valid = ($urandom_range(0, 9) < 7);
      bus.pl_data  = 8'($urandom);
      bus.busy     = ($urandom_range(0, 9) < 3);
      resetn       = ($urandom_range(0, 599) != 0);
      tick();
    end
    resetn    = 1'b1;
    bus.start = 1'b0;
    bus.busy  = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
